// File: rtl/clock_disp_pkg.sv
// Shared constants and types for the six-digit clock display scanner.
package clock_disp_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low a..g patterns with dp off, indexed by BCD value.
  localparam logic [7:0] SEG_TABLE [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  // Slots 2 and 4 carry the hh.mm.ss separators.
  localparam logic [5:0] DP_SLOT_MASK = 6'b010100;

  typedef enum logic [2:0] {
    SlotSecOnes  = 3'd0,
    SlotSecTens  = 3'd1,
    SlotMinOnes  = 3'd2,
    SlotMinTens  = 3'd3,
    SlotHourOnes = 3'd4,
    SlotHourTens = 3'd5
  } slot_idx_t;

endpackage

// File: rtl/bcd7seg_04.sv
// Combinational BCD nibble to active-low segment decoder; non-BCD nibbles blank.
module bcd7seg_04
  import clock_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (nibble_i <= 4'd9) begin
      seg_o = SEG_TABLE[nibble_i];
    end
  end

endmodule

// File: rtl/seg_scan_04.sv
// Six-digit multiplexed 7-segment scanner with per-slot ghost blanking and frame snapshots.
// Optional build macro LEADING_ZERO_BLANK_EN blanks the hours tens digit when it is zero.
module seg_scan_04
  import clock_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic       clk_04,
  input  logic       rst_04,
  input  logic [7:0] hour_04,
  input  logic [7:0] min_04,
  input  logic [7:0] sec_04,
  output logic [7:0] seg_04,
  output logic [5:0] dig_04
);

  localparam int unsigned PrescW = $clog2(SCAN_DIV);

  logic [PrescW-1:0] presc_q, presc_d;
  slot_idx_t         idx_q, idx_d;
  logic [23:0]       snap_q, snap_d, snap_cur;
  logic [7:0]        seg_q, seg_d;
  logic [5:0]        dig_q, dig_d;
  logic              presc_wrap;
  logic              snap_load;
  logic [3:0]        nibble;
  logic [7:0]        dec_seg;

  assign presc_wrap = (presc_q == PrescW'(SCAN_DIV - 1));

  always_comb begin
    presc_d = presc_wrap ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_wrap) begin
      unique case (idx_q)
        SlotSecOnes:  idx_d = SlotSecTens;
        SlotSecTens:  idx_d = SlotMinOnes;
        SlotMinOnes:  idx_d = SlotMinTens;
        SlotMinTens:  idx_d = SlotHourOnes;
        SlotHourOnes: idx_d = SlotHourTens;
        SlotHourTens: idx_d = SlotSecOnes;
        default:      idx_d = SlotSecOnes;
      endcase
    end
  end

  // First cycle of every frame (including the one right after reset) takes a
  // fresh snapshot; that cycle already displays from the incoming values.
  assign snap_load = (idx_q == SlotSecOnes) && (presc_q == '0);
  assign snap_cur  = snap_load ? {hour_04, min_04, sec_04} : snap_q;
  assign snap_d    = snap_cur;

  always_comb begin
    nibble = 4'hF;
    unique case (idx_q)
      SlotSecOnes:  nibble = snap_cur[3:0];
      SlotSecTens:  nibble = snap_cur[7:4];
      SlotMinOnes:  nibble = snap_cur[11:8];
      SlotMinTens:  nibble = snap_cur[15:12];
      SlotHourOnes: nibble = snap_cur[19:16];
      SlotHourTens: nibble = snap_cur[23:20];
      default:      nibble = 4'hF;
    endcase
  end

  bcd7seg_04 u_dec (
    .nibble_i (nibble),
    .seg_o    (dec_seg)
  );

  always_comb begin
    seg_d = SEG_BLANK;
    dig_d = 6'b111111;
    if (presc_q >= PrescW'(BLANK_CYC)) begin
      dig_d = ~(6'b000001 << idx_q);
      seg_d = dec_seg;
      if (dec_seg != SEG_BLANK && DP_SLOT_MASK[idx_q]) begin
        seg_d[7] = 1'b0;
      end
`ifdef LEADING_ZERO_BLANK_EN
      if (idx_q == SlotHourTens && snap_cur[23:20] == 4'd0) begin
        seg_d = SEG_BLANK;
      end
`endif
    end
  end

  always_ff @(posedge clk_04) begin
    if (!rst_04) begin
      presc_q <= '0;
      idx_q   <= SlotSecOnes;
      snap_q  <= '0;
      seg_q   <= SEG_BLANK;
      dig_q   <= 6'b111111;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign seg_04 = seg_q;
  assign dig_04 = dig_q;

endmodule
